// File: rtl/vc_allocator_pkg.sv
// Shared router definitions: default port/VC counts, id widths and the
// per-input allocation FSM encoding.
package vc_allocator_pkg;

  localparam int DEF_PORT_NUM = 5;
  localparam int DEF_VC_NUM   = 4;
  localparam int DEF_PW       = $clog2(DEF_PORT_NUM);
  localparam int DEF_VW       = $clog2(DEF_VC_NUM);

  typedef logic [DEF_PW-1:0] port_id_t;
  typedef logic [DEF_VW-1:0] vc_id_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    WAIT   = ST_WAIT,
    ACTIVE = ST_ACTIVE
  } va_state_e;

endpackage

// File: rtl/vc_allocator_rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins; the
// pointer moves past the winner only when a grant is issued.
module rr_arbiter #(
  parameter int N  = 5,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          valid
);

  logic [IW-1:0] ptr;
  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (valid) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vc_allocator.sv
// VC allocation stage: per-input IDLE/WAIT/ACTIVE FSMs, one round-robin
// arbiter per output port and a lowest-free-VC pick guarded by a hold map.
module vc_allocator
  import vc_allocator_pkg::*;
#(
  parameter int PORT_NUM = DEF_PORT_NUM,
  parameter int VC_NUM   = DEF_VC_NUM,
  localparam int PW = $clog2(PORT_NUM),
  localparam int VW = $clog2(VC_NUM)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PORT_NUM-1:0]               in_req,
  input  logic [PORT_NUM-1:0][PW-1:0]       in_dest,
  input  logic [PORT_NUM-1:0]               in_tail_done,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]   vc_busy,
  output logic [PORT_NUM-1:0]               in_grant,
  output logic [PORT_NUM-1:0][VW-1:0]       in_vc,
  output logic [PORT_NUM-1:0][PW-1:0]       in_out_port,
  output logic [PORT_NUM-1:0]               out_alloc_valid,
  output logic [PORT_NUM-1:0][VW-1:0]       vc_req,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]   vc_free
);

  localparam logic [PW-1:0] LAST_PORT = PW'(PORT_NUM - 1);

  va_state_e state [PORT_NUM];
  logic [PORT_NUM-1:0][PW-1:0]     dest_q;
  logic [PORT_NUM-1:0][PW-1:0]     eff_dest;
  logic [PORT_NUM-1:0]             elig;
  logic [PORT_NUM-1:0]             win;
  logic [PORT_NUM-1:0][VC_NUM-1:0] hold;
  logic [PORT_NUM-1:0][VC_NUM-1:0] hold_next;
  logic [PORT_NUM-1:0][VC_NUM-1:0] free_vc;
  logic [PORT_NUM-1:0][VC_NUM-1:0] rel_mask;
  logic [PORT_NUM-1:0][VC_NUM-1:0] set_mask;
  logic [PORT_NUM-1:0]             any_free;
  logic [PORT_NUM-1:0][VW-1:0]     low_vc;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] arb_req;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] arb_grant;
  logic [PORT_NUM-1:0][PW-1:0]     arb_idx;
  logic [PORT_NUM-1:0]             arb_valid;

  // A waiting input arbitrates on the destination it latched, not the live bus.
  always_comb begin
    eff_dest = '0;
    elig     = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      eff_dest[i] = (state[i] == WAIT) ? dest_q[i] : in_dest[i];
      elig[i]     = (state[i] == WAIT) ||
                    (state[i] == IDLE && in_req[i] && in_dest[i] <= LAST_PORT);
    end
  end

  always_comb begin
    free_vc  = ~vc_busy & ~hold;
    any_free = '0;
    low_vc   = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      any_free[o] = |free_vc[o];
      for (int v = VC_NUM - 1; v >= 0; v--) begin
        if (free_vc[o][v]) low_vc[o] = VW'(v);
      end
    end
  end

  always_comb begin
    arb_req = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        arb_req[o][i] = elig[i] && (eff_dest[i] == PW'(o)) && any_free[o];
      end
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    rr_arbiter #(.N(PORT_NUM)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (arb_req[o]),
      .grant     (arb_grant[o]),
      .grant_idx (arb_idx[o]),
      .valid     (arb_valid[o])
    );
  end

  always_comb begin
    win = '0;
    for (int o = 0; o < PORT_NUM; o++) win = win | arb_grant[o];
  end

  // A releasing VC is still held this cycle, so it can never be set and cleared together.
  always_comb begin
    rel_mask = '0;
    set_mask = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (state[i] == ACTIVE && in_tail_done[i]) rel_mask[in_out_port[i]][in_vc[i]] = 1'b1;
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      if (arb_valid[o]) set_mask[o][low_vc[o]] = 1'b1;
    end
    hold_next = (hold & ~rel_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PORT_NUM; i++) state[i] <= IDLE;
      dest_q          <= '0;
      hold            <= '0;
      in_grant        <= '0;
      in_vc           <= '0;
      in_out_port     <= '0;
      out_alloc_valid <= '0;
      vc_req          <= '0;
      vc_free         <= '0;
    end else begin
      hold            <= hold_next;
      in_grant        <= win;
      out_alloc_valid <= arb_valid;
      vc_free         <= rel_mask;
      for (int i = 0; i < PORT_NUM; i++) begin
        case (state[i])
          IDLE: begin
            if (elig[i] && !win[i]) begin
              state[i]  <= WAIT;
              dest_q[i] <= in_dest[i];
            end
          end
          ACTIVE: begin
            if (in_tail_done[i]) state[i] <= IDLE;
          end
          default: ;
        endcase
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        if (arb_valid[o]) begin
          state[arb_idx[o]]       <= ACTIVE;
          in_vc[arb_idx[o]]       <= low_vc[o];
          in_out_port[arb_idx[o]] <= PW'(o);
          vc_req[o]               <= low_vc[o];
        end else begin
          vc_req[o] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vc_allocator.sv
// Bench for vc_allocator: hand-computed vector table, directed multi-cycle
// sequences and random traffic, all checked against a behavioural model.
module tb_vc_allocator;

  localparam int P = 5;
  localparam int V = 4;

  logic clk;
  logic rst;
  logic [P-1:0]        in_req;
  logic [P-1:0][2:0]   in_dest;
  logic [P-1:0]        in_tail_done;
  logic [P-1:0][V-1:0] vc_busy;
  logic [P-1:0]        in_grant;
  logic [P-1:0][1:0]   in_vc;
  logic [P-1:0][2:0]   in_out_port;
  logic [P-1:0]        out_alloc_valid;
  logic [P-1:0][1:0]   vc_req;
  logic [P-1:0][V-1:0] vc_free;

  vc_allocator dut (
    .clk             (clk),
    .rst             (rst),
    .in_req          (in_req),
    .in_dest         (in_dest),
    .in_tail_done    (in_tail_done),
    .vc_busy         (vc_busy),
    .in_grant        (in_grant),
    .in_vc           (in_vc),
    .in_out_port     (in_out_port),
    .out_alloc_valid (out_alloc_valid),
    .vc_req          (vc_req),
    .vc_free         (vc_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: 0 = idle, 1 = waiting, 2 = holding a VC.
  int m_state [P];
  int m_dest  [P];
  int m_vc    [P];
  int m_port  [P];
  int m_ptr   [P];
  bit m_hold  [P][V];
  logic [P-1:0]   e_grant;
  logic [P-1:0]   e_alloc;
  logic [P*V-1:0] e_free;
  int e_vcreq [P];
  bit just_reset;

  typedef struct {
    logic [4:0]  req;
    logic [14:0] dest;
    logic [4:0]  tail;
    logic [19:0] busy;
    logic [4:0]  exp_grant;
    logic [4:0]  exp_alloc;
    logic [19:0] exp_free;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int want [P];
    int winner [P];
    int winv [P];
    int fv;
    int idx;
    e_grant = '0;
    e_alloc = '0;
    e_free  = '0;
    if (rst == 1'b0) begin
      for (int i = 0; i < P; i++) begin
        m_state[i] = 0; m_dest[i] = 0; m_vc[i] = 0; m_port[i] = 0;
        m_ptr[i] = 0; e_vcreq[i] = 0;
        for (int v = 0; v < V; v++) m_hold[i][v] = 1'b0;
      end
      just_reset = 1'b1;
      return;
    end
    just_reset = 1'b0;
    for (int i = 0; i < P; i++) begin
      want[i] = -1;
      if (m_state[i] == 1) want[i] = m_dest[i];
      else if (m_state[i] == 0 && in_req[i] && in_dest[i] < P) want[i] = int'(in_dest[i]);
    end
    for (int o = 0; o < P; o++) begin
      winner[o] = -1;
      winv[o]   = 0;
      fv        = -1;
      for (int v = 0; v < V; v++)
        if (fv < 0 && !vc_busy[o][v] && !m_hold[o][v]) fv = v;
      if (fv >= 0) begin
        winv[o] = fv;
        for (int k = 0; k < P; k++) begin
          idx = (m_ptr[o] + k) % P;
          if (winner[o] < 0 && want[idx] == o) winner[o] = idx;
        end
      end
    end
    for (int i = 0; i < P; i++) begin
      if (m_state[i] == 2 && in_tail_done[i]) begin
        e_free[m_port[i]*V + m_vc[i]] = 1'b1;
        m_hold[m_port[i]][m_vc[i]] = 1'b0;
        m_state[i] = 0;
      end else if (m_state[i] == 0 && want[i] >= 0) begin
        m_state[i] = 1;
        m_dest[i]  = want[i];
      end
    end
    for (int o = 0; o < P; o++) begin
      if (winner[o] >= 0) begin
        m_state[winner[o]] = 2;
        m_vc[winner[o]]    = winv[o];
        m_port[winner[o]]  = o;
        m_hold[o][winv[o]] = 1'b1;
        m_ptr[o]           = (winner[o] + 1) % P;
        e_grant[winner[o]] = 1'b1;
        e_alloc[o]         = 1'b1;
        e_vcreq[o]         = winv[o];
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("in_grant", 32'(in_grant), 32'(e_grant));
    chk("out_alloc_valid", 32'(out_alloc_valid), 32'(e_alloc));
    chk("vc_free", 32'(vc_free), 32'(e_free));
    for (int o = 0; o < P; o++)
      if (e_alloc[o] || just_reset) chk($sformatf("vc_req[%0d]", o), 32'(vc_req[o]), 32'(e_vcreq[o]));
    for (int i = 0; i < P; i++) begin
      if (m_state[i] == 2 || just_reset) begin
        chk($sformatf("in_vc[%0d]", i), 32'(in_vc[i]), 32'(m_vc[i]));
        chk($sformatf("in_out_port[%0d]", i), 32'(in_out_port[i]), 32'(m_port[i]));
      end
    end
  endtask

  task automatic idle_inputs();
    in_req = '0; in_dest = '0; in_tail_done = '0; vc_busy = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();

    tbl[0] = '{5'b00001, 15'd2,   5'b00000, 20'h0, 5'b00001, 5'b00100, 20'h00000};
    tbl[1] = '{5'b00000, 15'd0,   5'b00001, 20'h0, 5'b00000, 5'b00000, 20'h00100};
    tbl[2] = '{5'b00011, 15'd25,  5'b00000, 20'h0, 5'b00011, 5'b01010, 20'h00000};
    tbl[3] = '{5'b00000, 15'd0,   5'b00011, 20'h0, 5'b00000, 5'b00000, 20'h01010};
    tbl[4] = '{5'b00100, 15'd448, 5'b00000, 20'h0, 5'b00000, 5'b00000, 20'h00000};
    tbl[5] = '{5'b00100, 15'd448, 5'b01000, 20'h0, 5'b00000, 5'b00000, 20'h00000};
    tbl[6] = '{5'b00100, 15'd0,   5'b00000, 20'h0, 5'b00100, 5'b00001, 20'h00000};
    tbl[7] = '{5'b00000, 15'd0,   5'b00100, 20'h0, 5'b00000, 5'b00000, 20'h00001};

    do_reset();
    chk("reset_grant", 32'(in_grant), 32'h0);
    chk("reset_vc_free", 32'(vc_free), 32'h0);

    for (int n = 0; n < 8; n++) begin
      in_req = tbl[n].req; in_dest = tbl[n].dest;
      in_tail_done = tbl[n].tail; vc_busy = tbl[n].busy;
      cycle();
      chk($sformatf("tbl%0d_grant", n), 32'(in_grant), 32'(tbl[n].exp_grant));
      chk($sformatf("tbl%0d_alloc", n), 32'(out_alloc_valid), 32'(tbl[n].exp_alloc));
      chk($sformatf("tbl%0d_free", n), 32'(vc_free), 32'(tbl[n].exp_free));
    end
    chk("single_vc", 32'(in_vc[0]), 32'd0);

    // Contention on output 4: order 0,1,3 with VCs 0,1,2.
    do_reset();
    in_req = 5'b01011; in_dest = 15'd2084;
    cycle();
    chk("cont_g0", 32'(in_grant), 32'b00001);
    in_req = '0;
    cycle();
    chk("cont_g1", 32'(in_grant), 32'b00010);
    chk("cont_vc1", 32'(in_vc[1]), 32'd1);
    cycle();
    chk("cont_g3", 32'(in_grant), 32'b01000);
    chk("cont_vcreq", 32'(vc_req[4]), 32'd2);
    in_tail_done = 5'b01011;
    cycle();
    chk("cont_free", 32'(vc_free), 32'h70000);
    in_tail_done = '0;
    in_req = 5'b10001; in_dest = 15'd16388;
    cycle();
    chk("cont_ptr4", 32'(in_grant), 32'b10000);
    in_req = '0;
    cycle();
    chk("cont_next", 32'(in_grant), 32'b00001);
    chk("cont_next_vc", 32'(in_vc[0]), 32'd1);

    // Exhaustion on output 1.
    do_reset();
    vc_busy = 20'h000E0;
    in_req = 5'b00101; in_dest = 15'd65;
    cycle();
    chk("exh_g0", 32'(in_grant), 32'b00001);
    in_req = '0;
    cycle();
    chk("exh_wait", 32'(in_grant), 32'h0);
    cycle();
    chk("exh_noalloc", 32'(out_alloc_valid), 32'h0);
    in_tail_done = 5'b00001;
    cycle();
    chk("exh_free", 32'(vc_free), 32'h00010);
    chk("exh_nogrant_rel", 32'(in_grant), 32'h0);
    in_tail_done = '0;
    cycle();
    chk("exh_g2", 32'(in_grant), 32'b00100);
    chk("exh_vc2", 32'(in_vc[2]), 32'd0);

    // Reset with three inputs active and one waiting.
    do_reset();
    vc_busy = 20'h0000E;
    in_req = 5'b01111; in_dest = 15'd136;
    cycle();
    chk("mid_g", 32'(in_grant), 32'b00111);
    in_req = '0;
    cycle();
    idle_inputs();
    rst = 1'b0;
    cycle();
    chk("mid_rst_vc", 32'(in_vc), 32'h0);
    chk("mid_rst_port", 32'(in_out_port), 32'h0);
    rst = 1'b1;
    in_req = 5'b01000; in_dest = 15'd0;
    cycle();
    chk("mid_fresh", 32'(in_grant), 32'b01000);
    chk("mid_fresh_vc", 32'(in_vc[3]), 32'd0);

    // Random traffic against the model.
    in_req = '0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < P; i++) begin
        in_req[i]       = $urandom_range(0, 1);
        in_dest[i]      = 3'($urandom_range(0, 6));
        in_tail_done[i] = ($urandom_range(0, 3) == 0);
      end
      vc_busy = 20'($urandom & $urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
